banked_video_ram: RTL and testbench

BANKED_VIDEO_RAM -- requirements
Module: banked_video_ram

---
 rtl/banked_video_ram_if.sv | 35 +++
 rtl/banked_video_ram.sv | 143 ++++++++++++++
 tb/tb_banked_video_ram.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/banked_video_ram_if.sv
// Port bundle for banked_video_ram: two read/write ports plus the fill request/status group.
// No latency of its own; master drives requests, slave returns registered read data and fill status.
// No backpressure signals; both ports accept one access per cycle.
interface banked_video_ram_if #(
    parameter int BANK_ADDR_WIDTH = 13,
    parameter int BANK_SEL_WIDTH  = 3,
    parameter int DATA_WIDTH      = 8
);
    localparam int AW = BANK_ADDR_WIDTH + BANK_SEL_WIDTH;

    logic                  we_a;
    logic [AW-1:0]         addr_a;
    logic [DATA_WIDTH-1:0] din_a;
    logic [DATA_WIDTH-1:0] dout_a;

    logic                  we_b;
    logic [AW-1:0]         addr_b;
    logic [DATA_WIDTH-1:0] din_b;
    logic [DATA_WIDTH-1:0] dout_b;

    logic                  fill_start;
    logic [DATA_WIDTH-1:0] fill_value;
    logic                  fill_busy;
    logic                  fill_done;

    modport master (
        output we_a, addr_a, din_a, we_b, addr_b, din_b, fill_start, fill_value,
        input  dout_a, dout_b, fill_busy, fill_done
    );

    modport slave (
        input  we_a, addr_a, din_a, we_b, addr_b, din_b, fill_start, fill_value,
        output dout_a, dout_b, fill_busy, fill_done
    );
endinterface

// File: rtl/banked_video_ram.sv
// Banked true dual-port video RAM with optional whole-memory fill engine (`define VIDEO_RAM_FILL_EN).
// Latency: 1-cycle registered reads on both ports; fill runs 2**AW cycles.
// Backpressure: none; while filling, port B is taken over (writes ignored, reads return 0).
module banked_video_ram #(
    parameter int BANK_ADDR_WIDTH = 13,
    parameter int BANK_SEL_WIDTH  = 3,
    parameter int DATA_WIDTH      = 8
) (
    input logic               clk,
    input logic               rst_n,
    banked_video_ram_if.slave bus
);
    localparam int AW    = BANK_ADDR_WIDTH + BANK_SEL_WIDTH;
    localparam int NB    = 1 << BANK_SEL_WIDTH;
    localparam int DEPTH = 1 << BANK_ADDR_WIDTH;
    localparam int SW    = (BANK_SEL_WIDTH > 0) ? BANK_SEL_WIDTH : 1;

    logic                  fill_active;
    logic                  we_b_eff;
    logic [AW-1:0]         addr_b_eff;
    logic [DATA_WIDTH-1:0] din_b_eff;

    logic [SW-1:0] sel_a;
    logic [SW-1:0] sel_b;
    logic [SW-1:0] sel_a_q;
    logic [SW-1:0] sel_b_q;

    logic [NB-1:0][DATA_WIDTH-1:0] rd_a_all;
    logic [NB-1:0][DATA_WIDTH-1:0] rd_b_all;

`ifdef VIDEO_RAM_FILL_EN
    typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;

    fill_state_t           state;
    fill_state_t           state_nxt;
    logic [AW-1:0]         cnt;
    logic [AW-1:0]         cnt_nxt;
    logic [DATA_WIDTH-1:0] fval;
    logic [DATA_WIDTH-1:0] fval_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            fval  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            fval  <= fval_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        fval_nxt  = fval;
        case (state)
            IDLE: begin
                if (bus.fill_start) begin
                    state_nxt = FILL;
                    cnt_nxt   = '0;
                    fval_nxt  = bus.fill_value;
                end
            end
            FILL: begin
                // Hold the counter at the last address so a single pass never wraps.
                if (cnt == {AW{1'b1}}) state_nxt = DONE;
                else                   cnt_nxt   = cnt + AW'(1);
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign fill_active   = (state == FILL);
    assign bus.fill_busy = fill_active;
    assign bus.fill_done = (state == DONE);
    assign we_b_eff      = fill_active | bus.we_b;
    assign addr_b_eff    = fill_active ? cnt  : bus.addr_b;
    assign din_b_eff     = fill_active ? fval : bus.din_b;
`else
    logic unused_fill;
    assign unused_fill   = ^{bus.fill_start, bus.fill_value};
    assign fill_active   = 1'b0;
    assign bus.fill_busy = 1'b0;
    assign bus.fill_done = 1'b0;
    assign we_b_eff      = bus.we_b;
    assign addr_b_eff    = bus.addr_b;
    assign din_b_eff     = bus.din_b;
`endif

    if (BANK_SEL_WIDTH > 0) begin : g_sel
        assign sel_a = bus.addr_a[AW-1:BANK_ADDR_WIDTH];
        assign sel_b = addr_b_eff[AW-1:BANK_ADDR_WIDTH];
    end else begin : g_nosel
        assign sel_a = '0;
        assign sel_b = '0;
    end

    for (genvar i = 0; i < NB; i++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [DATA_WIDTH-1:0] q_a;
        logic [DATA_WIDTH-1:0] q_b;
        logic                  wr_a;
        logic                  wr_b;

        assign wr_a = bus.we_a & (sel_a == SW'(i));
        assign wr_b = we_b_eff & (sel_b == SW'(i));

        // Port A is written last so it wins a same-address collision with B or the fill.
        always_ff @(posedge clk) begin
            if (wr_b) mem[addr_b_eff[BANK_ADDR_WIDTH-1:0]] <= din_b_eff;
            if (wr_a) mem[bus.addr_a[BANK_ADDR_WIDTH-1:0]] <= bus.din_a;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q_a <= '0;
                q_b <= '0;
            end else begin
                q_a <= mem[bus.addr_a[BANK_ADDR_WIDTH-1:0]];
                q_b <= fill_active ? '0 : mem[addr_b_eff[BANK_ADDR_WIDTH-1:0]];
            end
        end

        assign rd_a_all[i] = q_a;
        assign rd_b_all[i] = q_b;
    end

    // Bank selects travel with the read so the output mux matches the data, not the current address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_a_q <= '0;
            sel_b_q <= '0;
        end else begin
            sel_a_q <= sel_a;
            sel_b_q <= sel_b;
        end
    end

    assign bus.dout_a = rd_a_all[sel_a_q];
    assign bus.dout_b = bus.fill_busy ? '0 : rd_b_all[sel_b_q];
endmodule

// File: tb/tb_banked_video_ram.sv
// Self-checking bench for banked_video_ram (4-bit bank address, 4 banks, 8-bit data).
// Reads are scored against a shadow memory and fill model one cycle after they are issued.
module tb_banked_video_ram;
    localparam int BAW = 4;
    localparam int BSW = 2;
    localparam int DW  = 8;
    localparam int N   = 64;
`ifdef VIDEO_RAM_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    banked_video_ram_if #(.BANK_ADDR_WIDTH(BAW), .BANK_SEL_WIDTH(BSW), .DATA_WIDTH(DW)) bus ();

    banked_video_ram #(.BANK_ADDR_WIDTH(BAW), .BANK_SEL_WIDTH(BSW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit         port_b;
        logic [7:0] val;
        bit         in_fill;
        string      tag;
    } sb_t;

    sb_t         sbq[$];
    logic [7:0]  model [N];
    bit          f_on;
    bit          f_done;
    int unsigned f_cnt;
    logic [7:0]  f_val;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit wa, input logic [5:0] aa, input logic [7:0] da, input bit ca,
                        input bit wb, input logic [5:0] ab, input logic [7:0] db, input bit cb,
                        input bit fs, input logic [7:0] fv, input string tag);
        sb_t e;
        bit  was_fill;
        bus.we_a = wa; bus.addr_a = aa; bus.din_a = da;
        bus.we_b = wb; bus.addr_b = ab; bus.din_b = db;
        bus.fill_start = fs; bus.fill_value = fv;
        was_fill = f_on;
        if (ca) begin
            e.port_b = 1'b0; e.val = model[aa]; e.in_fill = 1'b0; e.tag = {tag, "_a"};
            sbq.push_back(e);
        end
        if (cb) begin
            e.port_b = 1'b1; e.val = model[ab]; e.in_fill = was_fill; e.tag = {tag, "_b"};
            sbq.push_back(e);
        end
        @(posedge clk);
        if (f_on)    model[f_cnt] = f_val;
        else if (wb) model[ab] = db;
        if (wa)      model[aa] = da;
        if (f_on) begin
            if (f_cnt == N - 1) begin f_on = 1'b0; f_done = 1'b1; end
            else f_cnt++;
        end else if (f_done) begin
            f_done = 1'b0;
        end else if (fs && FILL_EN) begin
            f_on = 1'b1; f_cnt = 0; f_val = fv;
        end
        #1;
        check({tag, "_busy"}, 32'(bus.fill_busy), 32'(f_on));
        check({tag, "_done"}, 32'(bus.fill_done), 32'(f_done));
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check(e.tag, e.port_b ? 32'(bus.dout_b) : 32'(bus.dout_a),
                  (e.port_b && (e.in_fill || f_on)) ? 32'h0 : 32'(e.val));
        end
    endtask

    task automatic quiet_inputs();
        bus.we_a = 1'b0; bus.addr_a = '0; bus.din_a = '0;
        bus.we_b = 1'b0; bus.addr_b = '0; bus.din_b = '0;
        bus.fill_start = 1'b0; bus.fill_value = '0;
    endtask

    initial begin
        logic [5:0] ra;
        logic [5:0] rb;
        f_on = 1'b0; f_done = 1'b0; f_cnt = 0; f_val = '0;
        quiet_inputs();
        #12;
        check("rst_dout_a", 32'(bus.dout_a), 32'h0);
        check("rst_dout_b", 32'(bus.dout_b), 32'h0);
        check("rst_busy",   32'(bus.fill_busy), 32'h0);
        check("rst_done",   32'(bus.fill_done), 32'h0);
        #8 rst_n = 1'b1;

        // Known contents everywhere: A writes even words, B writes odd words.
        for (int i = 0; i < N / 2; i++)
            step(1'b1, 6'(2 * i), 8'(i * 7 + 3), 1'b0, 1'b1, 6'(2 * i + 1), 8'(8'hF0 ^ i), 1'b0,
                 1'b0, 8'h00, "init");

        step(1'b1, 6'h13, 8'hA5, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 8'h00, "wr13");
        step(1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 6'h13, 8'h00, 1'b1, 1'b0, 8'h00, "rd13b");
        step(1'b1, 6'h13, 8'h5A, 1'b1, 1'b0, 6'h13, 8'h00, 1'b1, 1'b0, 8'h00, "rdw13");
        step(1'b0, 6'h13, 8'h00, 1'b1, 1'b0, 6'h13, 8'h00, 1'b1, 1'b0, 8'h00, "rd13new");

        step(1'b1, 6'h05, 8'h11, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 8'h00, "wr05");
        step(1'b0, 6'h00, 8'h00, 1'b0, 1'b1, 6'h35, 8'h22, 1'b0, 1'b0, 8'h00, "wr35");
        step(1'b0, 6'h05, 8'h00, 1'b1, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 8'h00, "rd05");
        step(1'b0, 6'h35, 8'h00, 1'b1, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 8'h00, "rd35");
        step(1'b0, 6'h00, 8'h00, 1'b1, 1'b0, 6'h05, 8'h00, 1'b1, 1'b0, 8'h00, "rdbank0");

        step(1'b1, 6'h20, 8'h3C, 1'b1, 1'b1, 6'h20, 8'hC3, 1'b1, 1'b0, 8'h00, "coll20");
        step(1'b0, 6'h20, 8'h00, 1'b1, 1'b0, 6'h20, 8'h00, 1'b1, 1'b0, 8'h00, "rd20");

        for (int i = 0; i < 150; i++) begin
            ra = 6'($urandom_range(0, N - 1));
            rb = (i % 4 == 0) ? ra : 6'($urandom_range(0, N - 1));
            step(1'($urandom_range(0, 1)), ra, 8'($urandom), 1'b1,
                 1'($urandom_range(0, 1)), rb, 8'($urandom), 1'b1, 1'b0, 8'h00, "rnd");
        end

        // Fill pass (a no-op when the fill engine is not built in).
        step(1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b1, 8'h7E, "fstart");
        for (int j = 0; j < 70; j++) begin
            step(j == 20, 6'(j), 8'h99, 1'b1, 1'b1, 6'(N - 1 - j), 8'h44, 1'b1,
                 j == 30, 8'h11, "fill");
        end
        for (int i = 0; i < N; i++)
            step(1'b0, 6'(i), 8'h00, 1'b1, 1'b0, 6'(N - 1 - i), 8'h00, 1'b1, 1'b0, 8'h00, "fchk");

        // Reset lands ten cycles into a second fill.
        step(1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b1, 8'h3D, "f2start");
        for (int j = 0; j < 10; j++)
            step(1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 8'h00, "fill2");
        quiet_inputs();
        rst_n = 1'b0;
        f_on = 1'b0; f_done = 1'b0; f_cnt = 0;
        #1;
        check("rst_mid_busy",   32'(bus.fill_busy), 32'h0);
        check("rst_mid_done",   32'(bus.fill_done), 32'h0);
        check("rst_mid_dout_a", 32'(bus.dout_a), 32'h0);
        check("rst_mid_dout_b", 32'(bus.dout_b), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++)
            step(1'b0, 6'(i), 8'h00, 1'b1, 1'b0, 6'(i + 16), 8'h00, 1'b1, 1'b0, 8'h00, "postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
